// File: rtl/mem_wb_stage_pkg.sv
// Shared defines for the MEM/WB stage: reset level, bus types, stall bit
// positions and the stage-register action decode.
package mem_wb_stage_pkg;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [31:0] reg_bus_t;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // What the stage register does on the next edge.
  typedef enum logic [1:0] {
    ACT_BUBBLE  = 2'd0,
    ACT_CAPTURE = 2'd1,
    ACT_HOLD    = 2'd2
  } stage_act_e;

  // Flush beats everything; a stalled MEM behind a running WB must insert a
  // bubble so the held instruction is not written back twice.
  function automatic stage_act_e stage_action(input logic flush,
                                              input logic stall_mem,
                                              input logic stall_wb);
    stage_act_e act;
    if (flush == Stop) begin
      act = ACT_BUBBLE;
    end else if ((stall_mem == Stop) && (stall_wb == NoStop)) begin
      act = ACT_BUBBLE;
    end else if (stall_mem == NoStop) begin
      act = ACT_CAPTURE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/mem_wb_stage_llbit_reg.sv
// LL/SC link bit. Exception flush clears the link and overrides any write.
module llbit_reg
  import mem_wb_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic we,
  input  logic wdata,
  output logic llbit
);

  logic llbit_r;

  // Link bit: flush clears, otherwise a WB-stage LL/SC writes, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      llbit_r <= 1'b0;
    end else if (flush == Stop) begin
      llbit_r <= 1'b0;
    end else if (we == 1'b1) begin
      llbit_r <= wdata;
    end else begin
      llbit_r <= llbit_r;
    end
  end

  assign llbit = llbit_r;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: drives the regfile and hilo write ports, owns the
// LL/SC link bit and counts retired register writes.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  input  logic               mem_llbit_we,
  input  logic               mem_llbit_val,
  output logic [ADDR_W-1:0]  wb_wd,
  output logic               wb_wreg,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_whilo,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo,
  output logic               llbit_o,
  output logic [CNT_W-1:0]   retire_cnt
);

  stage_act_e        act_s;
  logic [ADDR_W-1:0] wb_wd_r;
  logic              wb_wreg_r;
  logic [DATA_W-1:0] wb_wdata_r;
  logic              wb_whilo_r;
  logic [DATA_W-1:0] wb_hi_r;
  logic [DATA_W-1:0] wb_lo_r;
  logic              wb_llbit_we_r;
  logic              wb_llbit_val_r;
  logic [CNT_W-1:0]  retire_cnt_r;
  logic              llbit_s;

  // Decode the stage action from flush and the MEM/WB stall bits.
  always_comb begin
    act_s = stage_action(flush, stall[STALL_MEM], stall[STALL_WB]);
  end

  // Stage register: bubble, capture or hold, one action per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wb_wd_r        <= {ADDR_W{1'b0}};
      wb_wreg_r      <= 1'b0;
      wb_wdata_r     <= {DATA_W{1'b0}};
      wb_whilo_r     <= 1'b0;
      wb_hi_r        <= {DATA_W{1'b0}};
      wb_lo_r        <= {DATA_W{1'b0}};
      wb_llbit_we_r  <= 1'b0;
      wb_llbit_val_r <= 1'b0;
    end else begin
      case (act_s)
        ACT_CAPTURE: begin
          wb_wd_r        <= mem_wd;
          wb_wreg_r      <= mem_wreg;
          wb_wdata_r     <= mem_wdata;
          wb_whilo_r     <= mem_whilo;
          wb_hi_r        <= mem_hi;
          wb_lo_r        <= mem_lo;
          wb_llbit_we_r  <= mem_llbit_we;
          wb_llbit_val_r <= mem_llbit_val;
        end
        ACT_HOLD: begin
          wb_wd_r        <= wb_wd_r;
          wb_wreg_r      <= wb_wreg_r;
          wb_wdata_r     <= wb_wdata_r;
          wb_whilo_r     <= wb_whilo_r;
          wb_hi_r        <= wb_hi_r;
          wb_lo_r        <= wb_lo_r;
          wb_llbit_we_r  <= wb_llbit_we_r;
          wb_llbit_val_r <= wb_llbit_val_r;
        end
        default: begin
          // ACT_BUBBLE and any illegal code load a side-effect-free bubble.
          wb_wd_r        <= {ADDR_W{1'b0}};
          wb_wreg_r      <= 1'b0;
          wb_wdata_r     <= {DATA_W{1'b0}};
          wb_whilo_r     <= 1'b0;
          wb_hi_r        <= {DATA_W{1'b0}};
          wb_lo_r        <= {DATA_W{1'b0}};
          wb_llbit_we_r  <= 1'b0;
          wb_llbit_val_r <= 1'b0;
        end
      endcase
    end
  end

  // Retired-write counter: a write commits on an edge where WB is not stalled.
  // Writes to $0 count too; flush does not touch the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if ((wb_wreg_r == 1'b1) && (stall[STALL_WB] == NoStop)) begin
      retire_cnt_r <= retire_cnt_r + CNT_W'(1);
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  llbit_reg u_llbit_reg (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .we    (wb_llbit_we_r),
    .wdata (wb_llbit_val_r),
    .llbit (llbit_s)
  );

  // Link-bit bypass so an SC in MEM sees an LL still sitting in WB.
  always_comb begin
    if (wb_llbit_we_r == 1'b1) begin
      llbit_o = wb_llbit_val_r;
    end else begin
      llbit_o = llbit_s;
    end
  end

  assign wb_wd      = wb_wd_r;
  assign wb_wreg    = wb_wreg_r;
  assign wb_wdata   = wb_wdata_r;
  assign wb_whilo   = wb_whilo_r;
  assign wb_hi      = wb_hi_r;
  assign wb_lo      = wb_lo_r;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: behavioural model compared every negedge plus
// hand-computed literal checks along a directed scenario.
module tb_mem_wb_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [4:0]  mem_wd = 5'd0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_whilo = 1'b0;
  logic [31:0] mem_hi = 32'd0;
  logic [31:0] mem_lo = 32'd0;
  logic        mem_llbit_we = 1'b0;
  logic        mem_llbit_val = 1'b0;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        llbit_o;
  logic [CW-1:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .STALL_W(6), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_val(mem_llbit_val),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .llbit_o(llbit_o), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llwe;
    logic        llval;
  } slot_t;

  slot_t m_wb   = '0;
  logic  m_link = 1'b0;
  int    m_cnt  = 0;

  // Model: what WB holds, the link bit and the number of committed writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wb = '0;
      m_link = 1'b0;
      m_cnt = 0;
    end else begin
      if (m_wb.wreg && !stall[5]) m_cnt = (m_cnt + 1) % (1 << CW);
      if (flush) m_link = 1'b0;
      else if (m_wb.llwe) m_link = m_wb.llval;
      if (flush || (stall[4] && !stall[5])) m_wb = '0;
      else if (!stall[4])
        m_wb = '{mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                 mem_llbit_we, mem_llbit_val};
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    chk("m_wd", 64'(wb_wd), 64'(m_wb.wd));
    chk("m_wreg", 64'(wb_wreg), 64'(m_wb.wreg));
    chk("m_wdata", 64'(wb_wdata), 64'(m_wb.wdata));
    chk("m_whilo", 64'(wb_whilo), 64'(m_wb.whilo));
    chk("m_hi", 64'(wb_hi), 64'(m_wb.hi));
    chk("m_lo", 64'(wb_lo), 64'(m_wb.lo));
    chk("m_llbit", 64'(llbit_o), 64'(m_wb.llwe ? m_wb.llval : m_link));
    chk("m_cnt", 64'(retire_cnt), 64'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic llwe, input logic llval,
                       input logic [5:0] st, input logic fl);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_llbit_we = llwe; mem_llbit_val = llval;
    mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
    stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with live MEM inputs.
    drive(5'd1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 6'd0, 1'b0);
    tick(); tick();
    chk("rst_wreg", 64'(wb_wreg), 64'd0);
    chk("rst_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_llbit", 64'(llbit_o), 64'd0);
    chk("rst_cnt", 64'(retire_cnt), 64'd0);
    rst = 1'b1;

    // Pass-through with HI/LO.
    drive(5'd5, 1'b1, 32'h12345678, 1'b0, 1'b0, 6'd0, 1'b0);
    mem_whilo = 1'b1; mem_hi = 32'hA5A5_0001; mem_lo = 32'h5A5A_0002;
    tick();
    chk("pt_wd", 64'(wb_wd), 64'd5);
    chk("pt_wdata", 64'(wb_wdata), 64'h12345678);
    chk("pt_hi", 64'(wb_hi), 64'hA5A5_0001);
    chk("pt_lo", 64'(wb_lo), 64'h5A5A_0002);
    chk("pt_cnt0", 64'(retire_cnt), 64'd0);
    drive(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("pt_cnt1", 64'(retire_cnt), 64'd1);
    chk("pt_whilo", 64'(wb_whilo), 64'd0);

    // MEM stalled, WB running: bubble.
    drive(5'd3, 1'b1, 32'hAA, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    drive(5'd4, 1'b1, 32'hBB, 1'b0, 1'b0, 6'b010000, 1'b0);
    tick();
    chk("bub_wreg", 64'(wb_wreg), 64'd0);
    chk("bub_cnt", 64'(retire_cnt), 64'd2);

    // LL then SC directly behind it.
    drive(5'd2, 1'b1, 32'h1000, 1'b1, 1'b1, 6'd0, 1'b0);
    tick();
    drive(5'd8, 1'b1, 32'd1, 1'b1, 1'b0, 6'd0, 1'b0);
    chk("ll_bypass", 64'(llbit_o), 64'd1);
    tick();
    chk("sc_bypass0", 64'(llbit_o), 64'd0);
    drive(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("sc_llbit0", 64'(llbit_o), 64'd0);
    chk("sc_cnt", 64'(retire_cnt), 64'd4);

    // Flush overrides a full stall and clears the link.
    drive(5'd9, 1'b1, 32'h9, 1'b1, 1'b1, 6'd0, 1'b0);
    tick();
    drive(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b110000, 1'b0);
    tick();
    chk("fl_pre_wreg", 64'(wb_wreg), 64'd1);
    drive(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b111111, 1'b1);
    tick();
    chk("fl_wreg", 64'(wb_wreg), 64'd0);
    chk("fl_wd", 64'(wb_wd), 64'd0);
    chk("fl_llbit", 64'(llbit_o), 64'd0);
    chk("fl_cnt", 64'(retire_cnt), 64'd4);

    // Full stall holds WB while MEM changes.
    drive(5'd7, 1'b1, 32'h77, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(5'(10 + i), 1'b1, 32'(i), 1'b0, 1'b0, 6'b110000, 1'b0);
      tick();
      chk("hold_wd", 64'(wb_wd), 64'd7);
      chk("hold_wdata", 64'(wb_wdata), 64'h77);
      chk("hold_cnt", 64'(retire_cnt), 64'd4);
    end
    drive(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("hold_rel_cnt", 64'(retire_cnt), 64'd5);

    // Sixteen writes (first to $0) wrap the 4-bit counter back to 5.
    for (int i = 0; i < 16; i++) begin
      drive(5'(i), 1'b1, 32'(i * 3), 1'b0, 1'b0, 6'd0, 1'b0);
      tick();
      if (i == 0) chk("r0_wd", 64'(wb_wd), 64'd0);
    end
    drive(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    chk("wrap_cnt", 64'(retire_cnt), 64'd5);

    // Asynchronous reset mid-cycle.
    drive(5'd6, 1'b1, 32'h66, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_wreg", 64'(wb_wreg), 64'd0);
    chk("arst_wd", 64'(wb_wd), 64'd0);
    chk("arst_cnt", 64'(retire_cnt), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_wd", 64'(wb_wd), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
